// File: rtl/imem_stream_loader.sv
// Packs handshaked 32-bit words into the cpu instruction image and sequences cpu reset around the load.
// Latency: word visible on the image one cycle after acceptance; in_ready drops once the image is complete.
module imem_stream_loader #(
    parameter int WORDS    = 1024,
    parameter int RST_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_word,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  reload,
    output logic [WORDS*32-1:0]   instruction_stream,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic [10:0]           word_count
);

    localparam int PW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [PW-1:0] PTR_LAST  = PW'(WORDS - 1);
    localparam logic [3:0]    HOLD_INIT = 4'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [10:0]           cnt_q, cnt_d;
    logic [3:0]            hold_q, hold_d;
    logic [WORDS*32-1:0]   stream_q, stream_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  load_done_q, load_done_d;
    logic                  in_ready_q, in_ready_d;
    logic [PW+4:0]         wr_base;
    logic                  hs;

    assign hs      = in_valid && (state_q == ST_LOAD);
    assign wr_base = {ptr_q, 5'd0};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        stream_d = stream_q;

        if (reload) begin
            // a handshake coinciding with reload is dropped
            state_d  = ST_LOAD;
            ptr_d    = '0;
            cnt_d    = '0;
            hold_d   = '0;
            stream_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (hs) begin
                        stream_d[wr_base +: 32] = in_word;
                        ptr_d = ptr_q + PW'(1);
                        cnt_d = cnt_q + 11'd1;
                        if (in_last || (ptr_q == PTR_LAST)) begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_INIT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end

        cpu_rst_d   = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
        in_ready_d  = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            stream_q    <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            stream_q    <= stream_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign instruction_stream = stream_q;
    assign cpu_rst            = cpu_rst_q;
    assign load_done          = load_done_q;
    assign in_ready           = in_ready_q;
    assign word_count         = cnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Two loaders (hold 2 and hold 1) share one stimulus stream; a behavioural image model checks both every cycle.
module tb_imem_stream_loader;

    localparam int WORDS = 1024;
    localparam int SW    = WORDS * 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_last, reload;
    logic [31:0] in_word;
    logic        rdy_a, rdy_b, crst_a, crst_b, done_a, done_b;
    logic [10:0] wc_a, wc_b;
    logic [SW-1:0] str_a, str_b;

    imem_stream_loader #(.WORDS(WORDS), .RST_HOLD(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(rdy_a), .reload(reload), .instruction_stream(str_a),
        .cpu_rst(crst_a), .load_done(done_a), .word_count(wc_a)
    );

    imem_stream_loader #(.WORDS(WORDS), .RST_HOLD(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(rdy_b), .reload(reload), .instruction_stream(str_b),
        .cpu_rst(crst_b), .load_done(done_b), .word_count(wc_b)
    );

    // Model: image, words accepted, whether still accepting, and when the image completed.
    logic [SW-1:0] m_img = '0;
    int            m_cnt = 0;
    bit            m_loading = 1'b1;
    int            cyc = 0;
    int            fin_cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || reload) begin
            m_img     <= '0;
            m_cnt     <= 0;
            m_loading <= 1'b1;
        end else if (m_loading && in_valid) begin
            m_img[m_cnt*32 +: 32] <= in_word;
            m_cnt <= m_cnt + 1;
            if (in_last || (m_cnt == WORDS - 1)) begin
                m_loading <= 1'b0;
                fin_cyc   <= cyc;
            end
        end
    end

    function automatic bit exp_rst(int h);
        return m_loading || ((cyc - fin_cyc) <= h);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_stream(string nm, logic [SW-1:0] act);
        n_tests++;
        if (act !== m_img) begin
            n_fail++;
            for (int i = 0; i < WORDS; i++) begin
                if (act[i*32 +: 32] !== m_img[i*32 +: 32]) begin
                    $display("FAIL %s: slot %0d got %h expected %h (t=%0t)",
                             nm, i, act[i*32 +: 32], m_img[i*32 +: 32], $time);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready_a", {31'd0, rdy_a}, {31'd0, m_loading});
            chk("in_ready_b", {31'd0, rdy_b}, {31'd0, m_loading});
            chk("cpu_rst_a", {31'd0, crst_a}, {31'd0, exp_rst(2)});
            chk("cpu_rst_b", {31'd0, crst_b}, {31'd0, exp_rst(1)});
            chk("load_done_a", {31'd0, done_a}, {31'd0, !exp_rst(2)});
            chk("load_done_b", {31'd0, done_b}, {31'd0, !exp_rst(1)});
            chk("word_count_a", {21'd0, wc_a}, m_cnt);
            chk("word_count_b", {21'd0, wc_b}, m_cnt);
            chk_stream("stream_a", str_a);
            chk_stream("stream_b", str_b);
        end
    end

    // Entered and left at a falling edge; idle cycles carry noise that must be ignored.
    task automatic send(logic [31:0] w, bit last, int gap);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_word  = $urandom;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_reload(bit with_valid);
        reload   = 1'b1;
        in_valid = with_valid;
        in_word  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic offer_idle(int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_word  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0; in_word = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_in_ready", {31'd0, rdy_a}, 32'd1);
        chk("rst_cpu_rst", {31'd0, crst_a}, 32'd1);
        chk("rst_load_done", {31'd0, done_a}, 32'd0);
        chk("rst_word_count", {21'd0, wc_a}, 32'd0);
        chk("rst_stream_zero", {31'd0, |str_a}, 32'd0);
        rst = 1'b0;

        // three-word program, valid held continuously
        send(32'h20010005, 1'b0, 0);
        send(32'h20020002, 1'b0, 0);
        send(32'h20030007, 1'b1, 0);
        chk("t1_hold_a_c1", {31'd0, crst_a}, 32'd1);
        chk("t1_hold_b_c1", {31'd0, crst_b}, 32'd1);
        chk("t1_ready_off", {31'd0, rdy_a}, 32'd0);
        @(negedge clk);
        chk("t1_hold_a_c2", {31'd0, crst_a}, 32'd1);
        chk("t1_hold_b_release", {31'd0, crst_b}, 32'd0);
        chk("t1_done_b", {31'd0, done_b}, 32'd1);
        @(negedge clk);
        chk("t1_hold_a_release", {31'd0, crst_a}, 32'd0);
        chk("t1_done_a", {31'd0, done_a}, 32'd1);
        chk("t1_slot0", str_a[31:0], 32'h20010005);
        chk("t1_slot1", str_a[63:32], 32'h20020002);
        chk("t1_slot2", str_a[95:64], 32'h20030007);
        chk("t1_upper_zero", {31'd0, |str_a[SW-1:96]}, 32'd0);
        chk("t1_count", {21'd0, wc_a}, 32'd3);

        // words offered in RUN are ignored; then a gapped load
        offer_idle(4);
        pulse_reload(1'b0);
        send(32'h10210008, 1'b0, 3);
        send(32'h14220008, 1'b1, 2);
        offer_idle(6);
        chk("t2_count", {21'd0, wc_a}, 32'd2);
        chk("t2_slot0", str_a[31:0], 32'h10210008);
        chk("t2_slot1", str_a[63:32], 32'h14220008);
        chk("t2_slot2_zero", str_a[95:64], 32'h0);

        // reload from RUN with a colliding word
        in_valid = 1'b1;
        in_word  = 32'hFFFFFFFF;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("t4_count", {21'd0, wc_a}, 32'd0);
        chk("t4_stream_zero", {31'd0, |str_a}, 32'd0);
        chk("t4_cpu_rst", {31'd0, crst_a}, 32'd1);
        chk("t4_load_done", {31'd0, done_a}, 32'd0);
        send(32'h08000034, 1'b1, 1);
        chk("t4_slot0", str_a[31:0], 32'h08000034);
        offer_idle(4);

        // randomized loads with gaps, early ends and mid-load reloads
        for (int l = 0; l < 25; l++) begin
            int n;
            pulse_reload(1'($urandom_range(0, 1)));
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 29) == 0) pulse_reload(1'b1);
                send($urandom, (k == n - 1) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
            end
            offer_idle($urandom_range(0, 5));
        end

        // reset together with reload and a handshake, five words in
        pulse_reload(1'b0);
        for (int k = 0; k < 5; k++) send($urandom, 1'b0, 0);
        rst      = 1'b1;
        reload   = 1'b1;
        in_valid = 1'b1;
        in_word  = $urandom;
        @(negedge clk);
        rst      = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("t5_stream_zero", {31'd0, |str_a}, 32'd0);
        chk("t5_count", {21'd0, wc_a}, 32'd0);
        chk("t5_ready", {31'd0, rdy_a}, 32'd1);
        chk("t5_cpu_rst", {31'd0, crst_a}, 32'd1);

        // full buffer without in_last; a 1025th word is refused
        for (int i = 0; i < WORDS; i++) send(32'(i), 1'b0, 0);
        chk("t3_ready_off", {31'd0, rdy_a}, 32'd0);
        chk("t3_cpu_rst", {31'd0, crst_a}, 32'd1);
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("t3_count", {21'd0, wc_a}, 32'd1024);
        chk("t3_slot1023", str_a[SW-1 -: 32], 32'h000003FF);
        chk("t3_slot0", str_a[31:0], 32'h0);
        chk("t3_done", {31'd0, done_a}, 32'd1);
        @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
